// File: rtl/br_wb_arbiter.sv
// Write-back arbiter: grants one ALU or memory register-bank write per cycle and flags decode RAW hazards.
// Optional build macro BR_ARB_RR_EN selects round-robin arbitration in place of memory-priority with starvation escape.
module br_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  output logic        m_ready,
  output logic [4:0]  WR,
  output logic [31:0] DW,
  output logic        RegEn,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        hazard
);

  logic        w_grant_a;
  logic        w_grant_m;
  logic [4:0]  r_wr;
  logic [31:0] r_dw;
  logic        r_regen;
  logic        w_hit1;
  logic        w_hit2;

`ifdef BR_ARB_RR_EN
  // Last-granted pointer:
  //   state  | meaning
  //   LAST_A | ALU won most recently; memory wins the next tie
  //   LAST_M | memory won most recently; ALU wins the next tie
  typedef enum logic {LAST_A = 1'b0, LAST_M = 1'b1} last_e;
  last_e r_last;
  last_e w_last_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_last <= LAST_A;
    else     r_last <= w_last_nxt;
  end

  always_comb begin
    w_last_nxt = r_last;
    if (w_grant_a)      w_last_nxt = LAST_A;
    else if (w_grant_m) w_last_nxt = LAST_M;
  end
`else
  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);
  logic [3:0] r_starve;
  logic [3:0] w_starve_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_starve <= 4'd0;
    else     r_starve <= w_starve_nxt;
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!a_valid || w_grant_a)          w_starve_nxt = 4'd0;
    else if (r_starve < LP_STARVE_MAX)  w_starve_nxt = r_starve + 4'd1;
  end
`endif

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_m = 1'b0;
    if (!rst) begin
      if (a_valid && !m_valid)      w_grant_a = 1'b1;
      else if (m_valid && !a_valid) w_grant_m = 1'b1;
      else if (a_valid && m_valid) begin
`ifdef BR_ARB_RR_EN
        if (r_last == LAST_M) w_grant_a = 1'b1;
        else                  w_grant_m = 1'b1;
`else
        if (r_starve == LP_STARVE_MAX) w_grant_a = 1'b1;
        else                           w_grant_m = 1'b1;
`endif
      end
    end
  end

  assign a_ready = w_grant_a;
  assign m_ready = w_grant_m;

  // Writes to $zero are accepted but never reach the bank; WR/DW keep the last real write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 5'd0;
      r_dw    <= 32'd0;
      r_regen <= 1'b0;
    end else begin
      r_regen <= 1'b0;
      if (w_grant_a && (a_addr != 5'd0)) begin
        r_wr    <= a_addr;
        r_dw    <= a_data;
        r_regen <= 1'b1;
      end else if (w_grant_m && (m_addr != 5'd0)) begin
        r_wr    <= m_addr;
        r_dw    <= m_data;
        r_regen <= 1'b1;
      end
    end
  end

  assign WR    = r_wr;
  assign DW    = r_dw;
  assign RegEn = r_regen;

  always_comb begin
    w_hit1 = (rd_addr1 != 5'd0) &&
             ((a_valid && (a_addr == rd_addr1)) ||
              (m_valid && (m_addr == rd_addr1)) ||
              (r_regen && (r_wr == rd_addr1)));
    w_hit2 = (rd_addr2 != 5'd0) &&
             ((a_valid && (a_addr == rd_addr2)) ||
              (m_valid && (m_addr == rd_addr2)) ||
              (r_regen && (r_wr == rd_addr2)));
  end

  assign hazard = w_hit1 || w_hit2;

endmodule

// File: tb/tb_br_wb_arbiter.sv
// Directed self-checking bench for br_wb_arbiter; expectations follow BR_ARB_RR_EN when it is defined.
module tb_br_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_ready;
  logic [4:0]  WR;
  logic [31:0] DW;
  logic        RegEn;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        hazard;

  int errors = 0;
  int checks = 0;

  br_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .WR(WR), .DW(DW), .RegEn(RegEn),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_m;
    rst = 1'b1; a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1111_0001;
    m_valid = 1'b1; m_addr = 5'd2; m_data = 32'h2222_0002;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;

    // Reset held two cycles with both requesters valid
    #1;
    check("rst_a_ready0", {31'd0, a_ready}, 32'd0);
    check("rst_m_ready0", {31'd0, m_ready}, 32'd0);
    tick();
    check("rst_regen0", {31'd0, RegEn}, 32'd0);
    check("rst_wr0", {27'd0, WR}, 32'd0);
    check("rst_dw0", DW, 32'd0);
    check("rst_a_ready1", {31'd0, a_ready}, 32'd0);
    check("rst_m_ready1", {31'd0, m_ready}, 32'd0);
    tick();
    check("rst_regen1", {31'd0, RegEn}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_m_ready", {31'd0, m_ready}, 32'd1);
    check("post_rst_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    check("post_rst_regen", {31'd0, RegEn}, 32'd1);
    check("post_rst_wr", {27'd0, WR}, 32'd2);
    check("post_rst_dw", DW, 32'h2222_0002);
    tick();

    // Single ALU write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    check("single_a_ready", {31'd0, a_ready}, 32'd1);
    check("single_m_ready", {31'd0, m_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    check("single_regen", {31'd0, RegEn}, 32'd1);
    check("single_wr", {27'd0, WR}, 32'd5);
    check("single_dw", DW, 32'hDEAD_BEEF);
    tick();
    check("single_regen_off", {31'd0, RegEn}, 32'd0);
    check("single_wr_hold", {27'd0, WR}, 32'd5);

    // Conflict on the same destination
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0003;
    m_valid = 1'b1; m_addr = 5'd3;
    for (int k = 1; k <= 5; k++) begin
      m_data = 32'h0000_1000 + 32'(k);
`ifdef BR_ARB_RR_EN
      exp_m = (k % 2) == 1;
`else
      exp_m = (k <= 4);
`endif
      #1;
      check($sformatf("conf%0d_m_ready", k), {31'd0, m_ready}, {31'd0, exp_m});
      check($sformatf("conf%0d_a_ready", k), {31'd0, a_ready}, {31'd0, ~exp_m});
      tick();
      check($sformatf("conf%0d_dw", k), DW, exp_m ? (32'h0000_1000 + 32'(k)) : 32'hAAAA_0003);
    end
    a_valid = 1'b0; m_valid = 1'b0;
    check("conf_wr", {27'd0, WR}, 32'd3);

    // Write to $zero is accepted but suppressed
    m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h0000_1234;
    #1;
    check("zero_m_ready", {31'd0, m_ready}, 32'd1);
    tick();
    m_valid = 1'b0;
    check("zero_regen", {31'd0, RegEn}, 32'd0);
    check("zero_wr_hold", {27'd0, WR}, 32'd3);
`ifdef BR_ARB_RR_EN
    check("zero_dw_hold", DW, 32'h0000_1005);
`else
    check("zero_dw_hold", DW, 32'hAAAA_0003);
`endif

    // Hazard detection
    rd_addr1 = 5'd7; m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h0000_0077;
    #1;
    check("haz_pending", {31'd0, hazard}, 32'd1);
    tick();
    m_valid = 1'b0;
    #1;
    check("haz_inflight_regen", {31'd0, RegEn}, 32'd1);
    check("haz_inflight_wr", {27'd0, WR}, 32'd7);
    check("haz_inflight", {31'd0, hazard}, 32'd1);
    tick();
    check("haz_clear", {31'd0, hazard}, 32'd0);
    rd_addr1 = 5'd0; rd_addr2 = 5'd0; a_valid = 1'b1; a_addr = 5'd0;
    #1;
    check("haz_zero", {31'd0, hazard}, 32'd0);
    rd_addr2 = 5'd9; a_addr = 5'd9;
    #1;
    check("haz_rd2", {31'd0, hazard}, 32'd1);
    a_valid = 1'b0; rd_addr2 = 5'd0;
    tick();

    // Back-to-back A, M, A
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000_0A10;
    #1;
    check("b2b_a1_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0; m_valid = 1'b1; m_addr = 5'd11; m_data = 32'h0000_0B11;
    #1;
    check("b2b_m_ready", {31'd0, m_ready}, 32'd1);
    check("b2b_w1_regen", {31'd0, RegEn}, 32'd1);
    check("b2b_w1_wr", {27'd0, WR}, 32'd10);
    check("b2b_w1_dw", DW, 32'h0000_0A10);
    tick();
    m_valid = 1'b0; a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h0000_0C12;
    #1;
    check("b2b_a2_ready", {31'd0, a_ready}, 32'd1);
    check("b2b_w2_regen", {31'd0, RegEn}, 32'd1);
    check("b2b_w2_wr", {27'd0, WR}, 32'd11);
    check("b2b_w2_dw", DW, 32'h0000_0B11);
    tick();
    a_valid = 1'b0;
    check("b2b_w3_regen", {31'd0, RegEn}, 32'd1);
    check("b2b_w3_wr", {27'd0, WR}, 32'd12);
    check("b2b_w3_dw", DW, 32'h0000_0C12);
    tick();
    check("b2b_idle", {31'd0, RegEn}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
